// File: rtl/fpga_system_led_pio.sv
// fpga_system_led_pio: Avalon-MM LED output port with per-bit set/clear
// registers and a per-bit hardware blink driven by a programmable prescaler.
module fpga_system_led_pio #(
    parameter int          WIDTH        = 9,
    parameter logic [31:0] RESET_VALUE  = 32'd0,
    parameter int          PERIOD_WIDTH = 26,
    parameter logic [31:0] RESET_PERIOD = 32'd24999999
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_BLINK_EN = 3'd1;
    localparam logic [2:0] ADDR_PERIOD   = 3'd2;
    localparam logic [2:0] ADDR_STATUS   = 3'd3;
    localparam logic [2:0] ADDR_OUTSET   = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

    localparam logic [WIDTH-1:0]        DATA_INIT   = RESET_VALUE[WIDTH-1:0];
    localparam logic [PERIOD_WIDTH-1:0] PERIOD_INIT = RESET_PERIOD[PERIOD_WIDTH-1:0];

    logic [WIDTH-1:0]        data_out_reg, data_out_next;
    logic [WIDTH-1:0]        blink_en_reg, blink_en_next;
    logic [PERIOD_WIDTH-1:0] period_reg,   period_next;
    logic [PERIOD_WIDTH-1:0] cnt_reg,      cnt_next;
    logic                    phase_reg,    phase_next;

    logic                    wr_en;
    logic [WIDTH-1:0]        wr_bits;
    logic [PERIOD_WIDTH-1:0] wr_period;

    // Upper writedata bits are intentionally discarded.
    wire unused_wdata = &{1'b0, writedata};

    assign wr_en     = chipselect & ~write_n;
    assign wr_bits   = writedata[WIDTH-1:0];
    assign wr_period = writedata[PERIOD_WIDTH-1:0];

    // Next-state: register writes plus the free-running blink prescaler.
    always_comb begin
        data_out_next = data_out_reg;
        blink_en_next = blink_en_reg;
        period_next   = period_reg;
        if (cnt_reg == '0) begin
            cnt_next   = period_reg;
            phase_next = ~phase_reg;
        end else begin
            cnt_next   = cnt_reg - PERIOD_WIDTH'(1);
            phase_next = phase_reg;
        end
        if (wr_en) begin
            case (address)
                ADDR_DATA:     data_out_next = wr_bits;
                ADDR_BLINK_EN: blink_en_next = wr_bits;
                ADDR_PERIOD: begin
                    // A period write restarts the half-period and wins over underflow.
                    period_next = wr_period;
                    cnt_next    = wr_period;
                    phase_next  = 1'b1;
                end
                ADDR_OUTSET:   data_out_next = data_out_reg | wr_bits;
                ADDR_OUTCLEAR: data_out_next = data_out_reg & ~wr_bits;
                default:       ;
            endcase
        end
    end

    // State registers with asynchronous reset to the power-on configuration.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out_reg <= DATA_INIT;
            blink_en_reg <= '0;
            period_reg   <= PERIOD_INIT;
            cnt_reg      <= PERIOD_INIT;
            phase_reg    <= 1'b1;
        end else begin
            data_out_reg <= data_out_next;
            blink_en_reg <= blink_en_next;
            period_reg   <= period_next;
            cnt_reg      <= cnt_next;
            phase_reg    <= phase_next;
        end
    end

    // Blinking bits are forced low during the low phase.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_out
            assign out_port[gi] = data_out_reg[gi] & (~blink_en_reg[gi] | phase_reg);
        end
    endgenerate

    // Zero-wait-state read mux, zero-extended to the bus width.
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:     readdata[WIDTH-1:0]        = data_out_reg;
            ADDR_BLINK_EN: readdata[WIDTH-1:0]        = blink_en_reg;
            ADDR_PERIOD:   readdata[PERIOD_WIDTH-1:0] = period_reg;
            ADDR_STATUS:   readdata[WIDTH-1:0]        = out_port;
            default:       readdata                   = '0;
        endcase
    end

endmodule

// File: tb/tb_fpga_system_led_pio.sv
// Testbench for fpga_system_led_pio: table-driven register vectors plus
// hand-written blink, period-rewrite and reset sequences, with a scoreboard.
module tb_fpga_system_led_pio;

    localparam int W = 9;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [2:0]    address;
    logic          chipselect;
    logic          write_n;
    logic [31:0]   writedata;
    logic [31:0]   readdata;
    logic [W-1:0]  out_port;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        bit          is_wr;
        logic [2:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[$];

    fpga_system_led_pio #(
        .WIDTH(9),
        .RESET_VALUE(32'd0),
        .PERIOD_WIDTH(26),
        .RESET_PERIOD(32'd24999999)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .readdata(readdata),
        .out_port(out_port)
    );

    always #5 clk = ~clk;

    task automatic push_exp(input string name, input logic [31:0] val);
        exp_t e;
        e.name = name;
        e.val  = val;
        sb.push_back(e);
    endtask

    task automatic check_pop(input logic [31:0] act);
        exp_t e;
        e = sb.pop_front();
        checks++;
        if (act !== e.val) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", e.name, act, e.val);
        end else begin
            $display("ok   %s value=0x%0h", e.name, act);
        end
    endtask

    // Called at a falling edge: one write strobe across the next rising edge.
    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        #1;
        d          = readdata;
        chipselect = 1'b0;
    endtask

    // Blink expectation from the closed form: phase is high for the first
    // p+1 edges after the restart point, then alternates every p+1 edges.
    task automatic blink_run(input string tag, input int p, input int n,
                             input logic [W-1:0] data, input logic [W-1:0] be);
        logic [31:0] r;
        logic [W-1:0] ph;
        for (int k = 0; k < n; k++) begin
            ph = (((k / (p + 1)) % 2) == 0) ? {W{1'b1}} : {W{1'b0}};
            push_exp($sformatf("%s_out_k%0d", tag, k), 32'(data & (~be | ph)));
            check_pop(32'(out_port));
            push_exp($sformatf("%s_status_k%0d", tag, k), 32'(data & (~be | ph)));
            rd(3'd3, r);
            check_pop(r);
            @(negedge clk);
        end
    endtask

    task automatic add_vec(input bit w, input logic [2:0] a, input logic [31:0] d,
                           input logic [31:0] e);
        vec_t v;
        v.is_wr = w;
        v.addr  = a;
        v.data  = d;
        v.exp   = e;
        vecs.push_back(v);
    endtask

    initial begin
        logic [31:0] r;

        // Register vectors: write -> expected out_port, read -> expected readdata.
        add_vec(0, 3'd0, 32'h0, 32'h0);
        add_vec(0, 3'd1, 32'h0, 32'h0);
        add_vec(0, 3'd2, 32'h0, 32'h017D783F);
        add_vec(0, 3'd3, 32'h0, 32'h0);
        add_vec(1, 3'd0, 32'hFFFFFFA5, 32'h1A5);
        add_vec(0, 3'd0, 32'h0, 32'h1A5);
        add_vec(1, 3'd4, 32'h0000000A, 32'h1AF);
        add_vec(0, 3'd0, 32'h0, 32'h1AF);
        add_vec(1, 3'd5, 32'h00000100, 32'h0AF);
        add_vec(0, 3'd0, 32'h0, 32'h0AF);
        add_vec(0, 3'd4, 32'h0, 32'h0);
        add_vec(0, 3'd5, 32'h0, 32'h0);
        add_vec(1, 3'd6, 32'hFFFFFFFF, 32'h0AF);
        add_vec(1, 3'd7, 32'hFFFFFFFF, 32'h0AF);
        add_vec(0, 3'd6, 32'h0, 32'h0);
        add_vec(0, 3'd7, 32'h0, 32'h0);
        add_vec(0, 3'd0, 32'h0, 32'h0AF);
        add_vec(0, 3'd1, 32'h0, 32'h0);
        add_vec(0, 3'd2, 32'h0, 32'h017D783F);
        add_vec(1, 3'd3, 32'hFFFFFFFF, 32'h0AF);
        add_vec(0, 3'd3, 32'h0, 32'h0AF);
        add_vec(1, 3'd1, 32'hFFFFFFFF, 32'h0AF);
        add_vec(0, 3'd1, 32'h0, 32'h1FF);
        add_vec(1, 3'd1, 32'h00000000, 32'h0AF);
        add_vec(1, 3'd2, 32'hFFFFFFFF, 32'h0AF);
        add_vec(0, 3'd2, 32'h0, 32'h03FFFFFF);

        reset_n    = 1'b0;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
        repeat (3) @(negedge clk);
        push_exp("reset_out_in_reset", 32'h0);
        check_pop(32'(out_port));
        reset_n = 1'b1;
        @(negedge clk);
        push_exp("reset_out_after_release", 32'h0);
        check_pop(32'(out_port));

        foreach (vecs[i]) begin
            if (vecs[i].is_wr) begin
                push_exp($sformatf("vec%0d_wr_a%0d_out", i, vecs[i].addr), vecs[i].exp);
                wr(vecs[i].addr, vecs[i].data);
                check_pop(32'(out_port));
            end else begin
                push_exp($sformatf("vec%0d_rd_a%0d", i, vecs[i].addr), vecs[i].exp);
                rd(vecs[i].addr, r);
                check_pop(r);
                @(negedge clk);
            end
        end

        // Blink with period 3: runs of 4 cycles on bits 1:0.
        wr(3'd0, 32'h1FF);
        wr(3'd1, 32'h003);
        wr(3'd2, 32'd3);
        blink_run("blink_p3", 3, 20, 9'h1FF, 9'h003);

        // Now in a low phase; a period rewrite forces the bits high at once.
        push_exp("low_phase_before_rewrite", 32'h1FC);
        check_pop(32'(out_port));
        wr(3'd2, 32'd1);
        blink_run("blink_p1", 1, 10, 9'h1FF, 9'h003);

        // Period 0 toggles every cycle.
        wr(3'd2, 32'd0);
        blink_run("blink_p0", 0, 8, 9'h1FF, 9'h003);

        // Asynchronous reset mid-blink, away from any clock edge.
        #2;
        reset_n = 1'b0;
        #1;
        push_exp("async_reset_out", 32'h0);
        check_pop(32'(out_port));
        push_exp("async_reset_period", 32'h017D783F);
        rd(3'd2, r);
        check_pop(r);
        push_exp("async_reset_blink_en", 32'h0);
        rd(3'd1, r);
        check_pop(r);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Counter restarted at the full reset period: no toggle in a short window.
        wr(3'd0, 32'h001);
        wr(3'd1, 32'h001);
        blink_run("after_reset", 24999999, 40, 9'h001, 9'h001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
